// File: rtl/frame_buffer_unpacker.sv
// frame_buffer_unpacker: reads packed 4/8/10-bit pixels from the 32-bit frame
// buffer RAM and streams them out one per valid/ready handshake.
module frame_buffer_unpacker #(
  parameter int ADDR_WIDTH  = 16,
  parameter int COUNT_WIDTH = 20
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [3:0]             i_pixel_width,
  input  logic [COUNT_WIDTH-1:0] i_pixel_count,
  output logic                   o_ram_read_enable,
  output logic [ADDR_WIDTH-1:0]  o_ram_address,
  input  logic [31:0]            i_ram_read_data,
  output logic [9:0]             o_pixel_data,
  output logic                   o_pixel_valid,
  input  logic                   i_pixel_ready,
  output logic                   o_busy,
  output logic                   o_frame_done
);
  localparam int PW = COUNT_WIDTH + 5;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t r_state, w_next;
  logic [3:0]             r_width;
  logic [COUNT_WIDTH-1:0] r_words_total, r_rd_idx, r_load_left, r_acc_left;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [63:0]            r_buf;
  logic [6:0]             r_bits;
  logic                   r_inflight;
  logic                   w_width_ok, w_go, w_accept, w_last, w_load, w_rd;
  logic [6:0]             w_used, w_keep;
  logic [PW-1:0]          w_bits_total;
  logic [COUNT_WIDTH-1:0] w_words;

  assign w_width_ok   = i_pixel_width == 4'd4 || i_pixel_width == 4'd8 || i_pixel_width == 4'd10;
  assign w_go         = r_state == IDLE && i_start && w_width_ok && !i_abort;
  assign w_bits_total = PW'(i_pixel_count) * PW'(i_pixel_width) + PW'(31);
  assign w_words      = COUNT_WIDTH'(w_bits_total >> 5);
  assign w_accept     = o_pixel_valid && i_pixel_ready;
  assign w_last       = w_accept && r_acc_left == COUNT_WIDTH'(1) && !i_abort;
  assign w_load       = r_state != IDLE && r_bits >= {3'b0, r_width} && r_load_left != '0 && (!o_pixel_valid || i_pixel_ready);
  assign w_used       = w_load ? {3'b0, r_width} : 7'd0;
  assign w_keep       = r_bits - w_used;
  // Keep the buffer within 64 bits: a new word is only requested once it fits below what remains.
  assign w_rd         = r_state == STREAM && !i_abort && !r_inflight && r_rd_idx != r_words_total && w_keep <= 7'd32;

  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    if (i_abort) w_next = IDLE;
    else if (w_go && i_pixel_count != '0) w_next = STREAM;
    else if (w_last) w_next = IDLE;
    else if (w_rd && r_rd_idx == r_words_total - COUNT_WIDTH'(1)) w_next = DRAIN;
  end

  always_comb begin
    o_ram_read_enable = w_rd;
    o_ram_address     = w_rd ? ADDR_WIDTH'(r_rd_idx) : r_addr;
    o_busy            = r_state != IDLE;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_width       <= '0;
      r_words_total <= '0;
      r_rd_idx      <= '0;
      r_load_left   <= '0;
      r_acc_left    <= '0;
      r_addr        <= '0;
      r_buf         <= '0;
      r_bits        <= '0;
      r_inflight    <= 1'b0;
      o_pixel_data  <= '0;
      o_pixel_valid <= 1'b0;
      o_frame_done  <= 1'b0;
    end else if (i_abort) begin
      r_buf         <= '0;
      r_bits        <= '0;
      r_inflight    <= 1'b0;
      o_pixel_valid <= 1'b0;
      o_frame_done  <= 1'b0;
    end else begin
      o_frame_done <= (w_go && i_pixel_count == '0) || w_last;
      if (w_go) begin
        r_width       <= i_pixel_width;
        r_words_total <= w_words;
        r_load_left   <= i_pixel_count;
        r_acc_left    <= i_pixel_count;
        r_rd_idx      <= '0;
        r_addr        <= '0;
        r_buf         <= '0;
        r_bits        <= '0;
        r_inflight    <= 1'b0;
      end else begin
        r_inflight <= w_rd;
        if (w_rd) begin
          r_addr   <= ADDR_WIDTH'(r_rd_idx);
          r_rd_idx <= r_rd_idx + COUNT_WIDTH'(1);
        end
        // Returned word lands directly below the bits still held after this cycle's pixel.
        r_buf  <= (r_buf << w_used) | (r_inflight ? ({i_ram_read_data, 32'b0} >> w_keep) : 64'd0);
        r_bits <= w_keep + (r_inflight ? 7'd32 : 7'd0);
        if (w_load) begin
          o_pixel_data <= r_buf[63:54] >> (4'd10 - r_width);
          r_load_left  <= r_load_left - COUNT_WIDTH'(1);
        end
        if (w_accept) r_acc_left <= r_acc_left - COUNT_WIDTH'(1);
        o_pixel_valid <= w_load ? 1'b1 : (w_accept ? 1'b0 : o_pixel_valid);
      end
    end
  end
endmodule

// File: tb/tb_frame_buffer_unpacker.sv
// tb_frame_buffer_unpacker: directed checks of frame_buffer_unpacker against
// hand-computed pixels and a bit-level unpacking model.
module tb_frame_buffer_unpacker;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, ready = 1'b0;
  logic [3:0]  pw = '0;
  logic [19:0] pc = '0;
  logic        rd_en, valid, busy, done;
  logic [15:0] addr;
  logic [31:0] rdata = '0;
  logic [9:0]  data;
  logic [31:0] mem [0:63];
  int          total = 0, bad = 0, cyc = 0;
  int          start_cyc, first_rd, first_valid;
  bit          busy_seen;
  logic [9:0]  q_pix [$];
  logic [15:0] q_addr [$];
  int          q_acc [$];
  int          q_done [$];

  frame_buffer_unpacker dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .i_abort(abort),
    .i_pixel_width(pw), .i_pixel_count(pc),
    .o_ram_read_enable(rd_en), .o_ram_address(addr), .i_ram_read_data(rdata),
    .o_pixel_data(data), .o_pixel_valid(valid), .i_pixel_ready(ready),
    .o_busy(busy), .o_frame_done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (rd_en) rdata <= mem[addr[5:0]];

  always @(negedge clk) begin
    if (rd_en) q_addr.push_back(addr);
    if (valid && ready) begin q_pix.push_back(data); q_acc.push_back(cyc); end
    if (done) q_done.push_back(cyc);
    if (busy) busy_seen = 1'b1;
    if (valid && first_valid < 0) first_valid = cyc;
    if (start && start_cyc < 0) start_cyc = cyc;
    if (rd_en && first_rd < 0) first_rd = cyc;
  end

  function automatic logic [9:0] model_pix(input int n, input int w);
    logic [9:0] v = '0;
    int b;
    for (int k = 0; k < w; k++) begin
      b = n * w + k;
      v = {v[8:0], mem[b / 32][31 - (b % 32)]};
    end
    return v;
  endfunction

  task automatic clear_mon();
    q_pix.delete(); q_addr.delete(); q_acc.delete(); q_done.delete();
    start_cyc = -1; first_rd = -1; first_valid = -1; busy_seen = 1'b0;
  endtask

  task automatic start_frame(input logic [3:0] w, input logic [19:0] n);
    @(posedge clk); #1;
    start = 1'b1; pw = w; pc = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    repeat (budget) begin
      @(posedge clk); #2;
      if (q_done.size() != 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic fill_lcg(input int n, input logic [31:0] seed);
    logic [31:0] x = seed;
    for (int i = 0; i < n; i++) begin x = x * 32'd1103515245 + 32'd12345; mem[i] = x; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({rd_en, valid, busy, done} !== 4'b0) begin bad++; $display("FAIL reset_ctrl got=%b want=0000", {rd_en, valid, busy, done}); end
    total++; if (addr !== 16'h0) begin bad++; $display("FAIL reset_addr got=%h want=0000", addr); end
    total++; if (data !== 10'h0) begin bad++; $display("FAIL reset_data got=%h want=000", data); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_width8();
    logic [9:0] e [4] = '{10'hAA, 10'hBB, 10'hCC, 10'hDD};
    bit ok;
    mem[0] = 32'hAABBCCDD; ready = 1'b1; clear_mon();
    start_frame(4'd8, 20'd4);
    wait_done(40, ok);
    total++; if (!ok) begin bad++; $display("FAIL w8_done_timeout got=0 want=1"); end
    total++; if (q_pix.size() != 4) begin bad++; $display("FAIL w8_npix got=%0d want=4", q_pix.size()); end
    for (int i = 0; i < 4; i++) begin
      total++; if (q_pix[i] !== e[i]) begin bad++; $display("FAIL w8_pix%0d got=%h want=%h", i, q_pix[i], e[i]); end
    end
    total++; if (q_addr.size() != 1 || q_addr[0] !== 16'h0) begin bad++; $display("FAIL w8_reads got=%0d want=1 at addr 0", q_addr.size()); end
    total++; if (first_rd != start_cyc + 1) begin bad++; $display("FAIL w8_rd_latency got=%0d want=%0d", first_rd, start_cyc + 1); end
    total++; if (first_valid != first_rd + 3) begin bad++; $display("FAIL w8_valid_latency got=%0d want=%0d", first_valid, first_rd + 3); end
    total++; if (q_acc[3] - q_acc[0] != 3) begin bad++; $display("FAIL w8_bubbles got=%0d want=3", q_acc[3] - q_acc[0]); end
    total++; if (q_done.size() != 1 || q_done[0] != q_acc[3] + 1) begin bad++; $display("FAIL w8_done_cycle got=%0d want=%0d", q_done[0], q_acc[3] + 1); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL w8_busy_after got=%b want=0", busy); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_width10();
    logic [9:0] e [4] = '{10'h3FF, 10'h001, 10'h2AA, 10'h155};
    bit ok;
    mem[0] = 32'hFFC01AA9; mem[1] = 32'h55000000; ready = 1'b1; clear_mon();
    start_frame(4'd10, 20'd4);
    wait_done(40, ok);
    total++; if (!ok) begin bad++; $display("FAIL w10_done_timeout got=0 want=1"); end
    for (int i = 0; i < 4; i++) begin
      total++; if (q_pix[i] !== e[i]) begin bad++; $display("FAIL w10_pix%0d got=%h want=%h", i, q_pix[i], e[i]); end
    end
    total++; if (q_addr.size() != 2 || q_addr[0] !== 16'd0 || q_addr[1] !== 16'd1) begin bad++; $display("FAIL w10_reads got=%0d want=2 at 0,1", q_addr.size()); end
    total++; if (q_acc[3] - q_acc[0] != 3) begin bad++; $display("FAIL w10_bubbles got=%0d want=3", q_acc[3] - q_acc[0]); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_width4();
    bit ok;
    mem[0] = 32'h12345678; ready = 1'b1; clear_mon();
    start_frame(4'd4, 20'd3);
    wait_done(40, ok);
    total++; if (!ok || q_pix.size() != 3) begin bad++; $display("FAIL w4_npix got=%0d want=3", q_pix.size()); end
    for (int i = 0; i < 3; i++) begin
      total++; if (q_pix[i] !== 10'(i + 1)) begin bad++; $display("FAIL w4_pix%0d got=%h want=%h", i, q_pix[i], 10'(i + 1)); end
    end
    total++; if (q_addr.size() != 1) begin bad++; $display("FAIL w4_reads got=%0d want=1", q_addr.size()); end
    total++; if (q_acc[2] - q_acc[0] != 2) begin bad++; $display("FAIL w4_bubbles got=%0d want=2", q_acc[2] - q_acc[0]); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_backpressure();
    logic [9:0] e [64];
    bit s7 = 0, s31 = 0, ok;
    int idx;
    fill_lcg(20, 32'hC0FFEE01);
    for (int i = 0; i < 64; i++) e[i] = model_pix(i, 10);
    ready = 1'b1; clear_mon();
    start_frame(4'd10, 20'd64);
    for (int t = 0; t < 400; t++) begin
      @(posedge clk); #1;
      if (q_done.size() != 0) break;
      if ((q_pix.size() == 7 && !s7) || (q_pix.size() == 31 && !s31)) begin
        idx = q_pix.size();
        if (idx == 7) s7 = 1; else s31 = 1;
        ready = 1'b0;
        repeat (5) begin
          @(negedge clk); #1;
          total++; if (valid !== 1'b1 || data !== e[idx]) begin bad++; $display("FAIL bp_hold%0d got=%b/%h want=1/%h", idx, valid, data, e[idx]); end
        end
        @(posedge clk); #1;
        ready = 1'b1;
      end
    end
    ok = q_done.size() != 0;
    total++; if (!ok || q_pix.size() != 64) begin bad++; $display("FAIL bp_npix got=%0d want=64", q_pix.size()); end
    for (int i = 0; i < 64; i++) begin
      total++; if (q_pix[i] !== e[i]) begin bad++; $display("FAIL bp_pix%0d got=%h want=%h", i, q_pix[i], e[i]); end
    end
    total++; if (q_addr.size() != 20) begin bad++; $display("FAIL bp_reads got=%0d want=20", q_addr.size()); end
    for (int i = 0; i < q_addr.size(); i++) begin
      total++; if (q_addr[i] !== 16'(i)) begin bad++; $display("FAIL bp_addr%0d got=%h want=%h", i, q_addr[i], 16'(i)); end
    end
    total++; if (q_acc[63] - q_acc[0] != 73) begin bad++; $display("FAIL bp_span got=%0d want=73", q_acc[63] - q_acc[0]); end
    total++; if (q_done.size() != 1 || q_done[0] != q_acc[63] + 1) begin bad++; $display("FAIL bp_done_cycle got=%0d want=%0d", q_done[0], q_acc[63] + 1); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_edges();
    bit ok;
    clear_mon(); ready = 1'b1;
    start_frame(4'd8, 20'd0);
    repeat (4) @(posedge clk);
    #2;
    total++; if (q_done.size() != 1 || q_done[0] != start_cyc + 1) begin bad++; $display("FAIL empty_done got=%0d pulses want=1 at %0d", q_done.size(), start_cyc + 1); end
    total++; if (q_addr.size() != 0 || busy_seen) begin bad++; $display("FAIL empty_quiet got=%0d reads busy=%b want=0 reads busy=0", q_addr.size(), busy_seen); end
    clear_mon();
    start_frame(4'd6, 20'd4);
    repeat (6) @(posedge clk);
    #2;
    total++; if (q_done.size() != 0 || q_addr.size() != 0 || busy_seen) begin bad++; $display("FAIL bad_width got=%0d/%0d/%b want=0/0/0", q_done.size(), q_addr.size(), busy_seen); end
    mem[0] = 32'hAABBCCDD; clear_mon();
    start_frame(4'd8, 20'd4);
    start = 1'b1; pw = 4'd4; pc = 20'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, ok);
    total++; if (!ok || q_pix.size() != 4 || q_pix[0] !== 10'hAA || q_pix[3] !== 10'hDD) begin bad++; $display("FAIL busy_start got=%0d pix first=%h last=%h want=4 AA DD", q_pix.size(), q_pix[0], q_pix[3]); end
    total++; if (q_addr.size() != 1 || q_done.size() != 1) begin bad++; $display("FAIL busy_start_rd got=%0d/%0d want=1/1", q_addr.size(), q_done.size()); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_abort();
    logic [9:0] e [10];
    bit ok;
    int na;
    fill_lcg(32, 32'h0BADF00D);
    for (int i = 0; i < 10; i++) e[i] = model_pix(i, 10);
    ready = 1'b1; clear_mon();
    start_frame(4'd10, 20'd100);
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      if (q_pix.size() == 10) break;
    end
    abort = 1'b1; ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    na = q_addr.size();
    total++; if (valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_next got=%b/%b want=0/0", valid, busy); end
    total++; if (q_pix.size() != 10) begin bad++; $display("FAIL abort_npix got=%0d want=10", q_pix.size()); end
    for (int i = 0; i < 10; i++) begin
      total++; if (q_pix[i] !== e[i]) begin bad++; $display("FAIL abort_pix%0d got=%h want=%h", i, q_pix[i], e[i]); end
    end
    repeat (5) @(posedge clk);
    #2;
    total++; if (q_done.size() != 0 || q_addr.size() != na) begin bad++; $display("FAIL abort_quiet got=%0d done reads=%0d want=0 done reads=%0d", q_done.size(), q_addr.size(), na); end
    mem[0] = 32'h0A0B0C0D; ready = 1'b1; clear_mon();
    start_frame(4'd8, 20'd4);
    wait_done(40, ok);
    total++; if (!ok || q_addr.size() != 1 || q_addr[0] !== 16'h0) begin bad++; $display("FAIL abort_restart_addr got=%0d reads addr=%h want=1 reads addr=0000", q_addr.size(), q_addr[0]); end
    for (int i = 0; i < 4; i++) begin
      total++; if (q_pix[i] !== 10'(i + 10)) begin bad++; $display("FAIL abort_restart_pix%0d got=%h want=%h", i, q_pix[i], 10'(i + 10)); end
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_async_reset();
    bit ok;
    fill_lcg(32, 32'h13572468);
    ready = 1'b1; clear_mon();
    start_frame(4'd10, 20'd100);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++; if ({rd_en, valid, busy, done} !== 4'b0) begin bad++; $display("FAIL arst_ctrl got=%b want=0000", {rd_en, valid, busy, done}); end
    total++; if (addr !== 16'h0 || data !== 10'h0) begin bad++; $display("FAIL arst_addr_data got=%h/%h want=0000/000", addr, data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem[0] = 32'h11223344; clear_mon();
    start_frame(4'd8, 20'd4);
    wait_done(40, ok);
    total++; if (!ok || q_pix.size() != 4 || q_pix[3] !== 10'h44) begin bad++; $display("FAIL arst_recover got=%0d pix last=%h want=4 44", q_pix.size(), q_pix[3]); end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_width8();
    test_width10();
    test_width4();
    test_backpressure();
    test_edges();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule
